io_input_debouncer: RTL and testbench

Parametrised input-conditioning block between the board pads (push-buttons, slide switches) and the single-cycle core's memory-mapped input registers. Per channel it synchronises the raw pad, normalises polarity, and debounces with a programmable stability count. It outputs a clean level, one-cycle press/release pulses, and a sticky press latch that software can clear, plus a level interrupt request.

---
 rtl/io_pkg.sv | 14 +
 rtl/io_debounce_ch.sv | 83 ++++++++
 rtl/io_input_debouncer.sv | 42 ++++
 tb/tb_io_input_debouncer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared types and default constants for the board input-conditioning blocks.
// Imported by the debouncer channel and the top-level wrapper.
package io_pkg;

    typedef enum logic {
        DB_STABLE,
        DB_COUNTING
    } db_state_t;

    localparam int IO_NUM_BTN          = 4;
    localparam int IO_DEBOUNCE_DEFAULT = 20;
    localparam int IO_SYNC_STAGES      = 2;

endpackage

// File: rtl/io_debounce_ch.sv
// One input channel: synchroniser, polarity normalise, debounce FSM,
// registered press/release pulses and a software-clearable press latch.
module io_debounce_ch
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_DEFAULT,
    parameter int SYNC_STAGES     = IO_SYNC_STAGES,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic clr,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic sticky
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic INACTIVE = (ACTIVE_LOW != 0);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   norm;
    db_state_t              state;
    logic [CW-1:0]          cnt;

    // Reset to the idle pad value so release of reset never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {SYNC_STAGES{INACTIVE}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
        end
    end

    assign norm = sync[SYNC_STAGES-1] ^ INACTIVE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= DB_STABLE;
            cnt           <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            sticky        <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            if (clr) begin
                sticky <= 1'b0;
            end
            unique case (state)
                DB_STABLE: begin
                    if (norm != level) begin
                        state <= DB_COUNTING;
                        cnt   <= CW'(1);
                    end
                end
                DB_COUNTING: begin
                    if (norm == level) begin
                        state <= DB_STABLE;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        level         <= ~level;
                        press_pulse   <= ~level;
                        release_pulse <= level;
                        // A press on the same edge as a clear keeps the latch set.
                        if (!level) begin
                            sticky <= 1'b1;
                        end
                        state <= DB_STABLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/io_input_debouncer.sv
// Multi-channel pad conditioner feeding the memory-mapped input registers;
// channels are independent and their press latches share one interrupt line.
module io_input_debouncer
    import io_pkg::*;
#(
    parameter int NUM_CH          = IO_NUM_BTN,
    parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_DEFAULT,
    parameter int SYNC_STAGES     = IO_SYNC_STAGES,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NUM_CH-1:0] i_raw,
    input  logic              i_clr_vld,
    input  logic [NUM_CH-1:0] i_clr_mask,
    output logic [NUM_CH-1:0] o_level,
    output logic [NUM_CH-1:0] o_press_pulse,
    output logic [NUM_CH-1:0] o_release_pulse,
    output logic [NUM_CH-1:0] o_press_sticky,
    output logic              o_irq
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        io_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_ch (
            .clk          (i_clk),
            .rst_n        (i_rst_n),
            .raw          (i_raw[g]),
            .clr          (i_clr_vld & i_clr_mask[g]),
            .level        (o_level[g]),
            .press_pulse  (o_press_pulse[g]),
            .release_pulse(o_release_pulse[g]),
            .sticky       (o_press_sticky[g])
        );
    end

    assign o_irq = |o_press_sticky;

endmodule

// File: tb/tb_io_input_debouncer.sv
// Scoreboard bench: stimulus queues expected output snapshots per edge,
// a monitor pops and compares them and flags any unexpected pulse.
module tb_io_input_debouncer;

    logic       clk;
    logic       rst_n;
    logic [3:0] raw;
    logic       clr_vld;
    logic [3:0] clr_mask;
    logic [3:0] level;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic [3:0] press_sticky;
    logic       irq;

    io_input_debouncer #(
        .NUM_CH         (4),
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2),
        .ACTIVE_LOW     (1)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_raw          (raw),
        .i_clr_vld      (clr_vld),
        .i_clr_mask     (clr_mask),
        .o_level        (level),
        .o_press_pulse  (press_pulse),
        .o_release_pulse(release_pulse),
        .o_press_sticky (press_sticky),
        .o_irq          (irq)
    );

    typedef struct {
        int         cyc;
        logic [3:0] lvl;
        logic [3:0] pp;
        logic [3:0] rp;
        logic [3:0] st;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_x;
    int   edge_n = 0;
    int   checks = 0;
    int   fails  = 0;
    int   e;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic expect_at(input int cyc, input logic [3:0] lvl,
                             input logic [3:0] pp, input logic [3:0] rp,
                             input logic [3:0] st, input string name);
        exp_t x;
        x.cyc = cyc; x.lvl = lvl; x.pp = pp; x.rp = rp; x.st = st;
        x.name = name;
        sb.push_back(x);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: sample 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        while (sb.size() > 0 && sb[0].cyc < edge_n) begin
            mon_x = sb.pop_front();
            checks++;
            fails++;
            $display("FAIL %s: expectation for edge %0d never sampled (now %0d)",
                     mon_x.name, mon_x.cyc, edge_n);
        end
        if (sb.size() > 0 && sb[0].cyc == edge_n) begin
            mon_x = sb.pop_front();
            checks++;
            if (level !== mon_x.lvl || press_pulse !== mon_x.pp ||
                release_pulse !== mon_x.rp || press_sticky !== mon_x.st ||
                irq !== (|mon_x.st)) begin
                fails++;
                $display("FAIL %s @edge %0d: got lvl=%h pp=%h rp=%h st=%h irq=%b, want lvl=%h pp=%h rp=%h st=%h irq=%b",
                         mon_x.name, edge_n, level, press_pulse, release_pulse,
                         press_sticky, irq, mon_x.lvl, mon_x.pp, mon_x.rp,
                         mon_x.st, |mon_x.st);
            end
        end else begin
            checks++;
            if (press_pulse !== 4'h0 || release_pulse !== 4'h0) begin
                fails++;
                $display("FAIL unexpected_pulse @edge %0d: got pp=%h rp=%h, want 0",
                         edge_n, press_pulse, release_pulse);
            end
        end
    end

    // Asynchronous reset must clear every output without waiting for a clock.
    always @(negedge rst_n) begin
        #1;
        checks++;
        if (level !== 4'h0 || press_pulse !== 4'h0 || release_pulse !== 4'h0 ||
            press_sticky !== 4'h0 || irq !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: got lvl=%h pp=%h rp=%h st=%h irq=%b, want all 0",
                     level, press_pulse, release_pulse, press_sticky, irq);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        raw      = 4'hF;
        clr_vld  = 1'b0;
        clr_mask = 4'h0;
        cycles(10);

        rst_n = 1'b1;
        e = edge_n;
        expect_at(e + 1, 4'h0, 4'h0, 4'h0, 4'h0, "reset_idle_first");
        expect_at(e + 20, 4'h0, 4'h0, 4'h0, 4'h0, "reset_idle_last");
        cycles(20);

        e = edge_n;
        raw = 4'h7;
        expect_at(e + 5, 4'h0, 4'h0, 4'h0, 4'h0, "press_before");
        expect_at(e + 6, 4'h8, 4'h8, 4'h0, 4'h8, "press_accept");
        expect_at(e + 7, 4'h8, 4'h0, 4'h0, 4'h8, "press_pulse_end");
        cycles(10);

        e = edge_n;
        raw = 4'h6;
        cycles(3);
        raw = 4'h7;
        expect_at(e + 6, 4'h8, 4'h0, 4'h0, 4'h8, "glitch_reject");
        expect_at(e + 8, 4'h8, 4'h0, 4'h0, 4'h8, "glitch_after");
        cycles(10);

        e = edge_n;
        raw = 4'hF;
        expect_at(e + 5, 4'h8, 4'h0, 4'h0, 4'h8, "release_before");
        expect_at(e + 6, 4'h0, 4'h0, 4'h8, 4'h8, "release_accept");
        expect_at(e + 7, 4'h0, 4'h0, 4'h0, 4'h8, "release_pulse_end");
        cycles(10);

        e = edge_n;
        clr_vld  = 1'b1;
        clr_mask = 4'h8;
        expect_at(e + 1, 4'h0, 4'h0, 4'h0, 4'h0, "clear_ch3");
        cycles(1);
        clr_vld  = 1'b0;
        clr_mask = 4'h0;
        cycles(5);

        e = edge_n;
        raw = 4'hD;
        expect_at(e + 6, 4'h2, 4'h2, 4'h0, 4'h2, "clear_collision");
        expect_at(e + 7, 4'h2, 4'h0, 4'h0, 4'h0, "clear_after_set");
        cycles(5);
        clr_vld  = 1'b1;
        clr_mask = 4'h2;
        cycles(2);
        clr_vld  = 1'b0;
        clr_mask = 4'h0;
        cycles(5);

        e = edge_n;
        raw = 4'hF;
        expect_at(e + 6, 4'h0, 4'h0, 4'h2, 4'h0, "release_ch1");
        cycles(10);

        e = edge_n;
        raw = 4'hE;
        expect_at(e + 6, 4'h1, 4'h1, 4'h0, 4'h1, "press_ch0");
        cycles(10);

        e = edge_n;
        raw = 4'hA;
        expect_at(e + 4, 4'h1, 4'h0, 4'h0, 4'h1, "midcount_pre_reset");
        cycles(4);
        rst_n = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        e = edge_n;
        expect_at(e + 5, 4'h0, 4'h0, 4'h0, 4'h0, "post_reset_wait");
        expect_at(e + 6, 4'h5, 4'h5, 4'h0, 4'h5, "post_reset_accept");
        expect_at(e + 7, 4'h5, 4'h0, 4'h0, 4'h5, "post_reset_hold");
        cycles(10);

        e = edge_n;
        raw = 4'hF;
        expect_at(e + 6, 4'h0, 4'h0, 4'h5, 4'h5, "release_multi");
        cycles(10);

        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
